// File: rtl/vga_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_timing_pkg
//
// Shared timing constants for the VGA raster generator: the default
// 640x480@60 Hz geometry, the totals and sync windows derived from it,
// the scan counter width, and a small window-decode helper.
// ---------------------------------------------------------------------------
package vga_timing_pkg;

  // Width of the horizontal and vertical scan counters (DrawX / DrawY).
  localparam int CNT_W = 10;

  // Default geometry: 640x480@60 Hz from a 50 MHz clock (25 MHz pixels).
  localparam int DEF_CLK_DIV   = 2;
  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  // Derived values for the default geometry.
  localparam int H_TOTAL  = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_VISIBLE + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_VISIBLE + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

  // One pixel of colour as it travels from the mapper to the DAC.
  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  // True when a counter value lies inside an inclusive [lo, hi] window.
  function automatic logic in_window(input logic [CNT_W-1:0] v,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/scan_counter.sv
// ---------------------------------------------------------------------------
// scan_counter
//
// Modulo-TOTAL counter used for both the horizontal and vertical scan
// positions. It advances on each enabled clock and wraps from TOTAL-1 to 0.
//
// Ports:
//   clk    in   clock
//   clr_n  in   asynchronous active-low clear
//   en     in   advance the count this clock
//   count  out  current position, 0 .. TOTAL-1
//   wrap   out  high on the enabled clock that takes count from TOTAL-1 to 0
// ---------------------------------------------------------------------------
module scan_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL = H_TOTAL
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             at_last;

  assign at_last = (count_q == LAST);
  assign wrap    = en && at_last;
  assign count   = count_q;

  // Next position: hold unless enabled, then step or wrap back to zero.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/vga_scan_generator.sv
// ---------------------------------------------------------------------------
// vga_scan_generator
//
// Generates VGA raster timing from the system clock. A clock divider makes
// one pixel strobe every CLK_DIV clocks; two scan counters track the beam
// position, which is handed to the colour mapper as DrawX/DrawY. Sync, blank
// and the mapper's colour are captured together in one output register so
// everything reaching the DAC belongs to the same pixel. A frame tick and a
// frame counter are provided for game logic.
//
// Ports:
//   Clk                in   system clock
//   Reset_n            in   asynchronous active-low reset
//   pixel_en           out  one-Clk strobe, once per pixel period
//   DrawX, DrawY       out  current horizontal / vertical scan position
//   Red, Green, Blue   in   colour for (DrawX, DrawY) from the mapper
//   VGA_HS, VGA_VS     out  registered syncs, active low
//   VGA_BLANK_N        out  high when the registered pixel is visible
//   VGA_R, VGA_G, VGA_B out registered colour, zero in blanking
//   frame_start        out  one-Clk pulse after each frame wrap
//   frame_count        out  frames completed since reset, wraps at 256
// ---------------------------------------------------------------------------
module vga_scan_generator
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic             Clk,
  input  logic             Reset_n,
  output logic             pixel_en,
  output logic [CNT_W-1:0] DrawX,
  output logic [CNT_W-1:0] DrawY,
  input  logic [7:0]       Red,
  input  logic [7:0]       Green,
  input  logic [7:0]       Blue,
  output logic             VGA_HS,
  output logic             VGA_VS,
  output logic             VGA_BLANK_N,
  output logic [7:0]       VGA_R,
  output logic [7:0]       VGA_G,
  output logic [7:0]       VGA_B,
  output logic             frame_start,
  output logic [7:0]       frame_count
);

  localparam int H_TOT = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_VIS_C    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS_C    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST_C = CNT_W'(H_VISIBLE + H_FP);
  localparam logic [CNT_W-1:0] HS_LAST_C  = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST_C = CNT_W'(V_VISIBLE + V_FP);
  localparam logic [CNT_W-1:0] VS_LAST_C  = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

  // A one-bit divider still exists when CLK_DIV is 1; it simply never
  // leaves zero, which keeps pixel_en permanently high.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;

  logic [CNT_W-1:0] hc, vc;
  logic             h_wrap, v_wrap;

  logic hs_raw, vs_raw, vis;
  rgb_t pix_rgb;

  logic hs_n_q, hs_n_d;
  logic vs_n_q, vs_n_d;
  logic blank_n_q, blank_n_d;
  rgb_t rgb_q, rgb_d;
  logic frame_start_q, frame_start_d;
  logic [7:0] frame_count_q, frame_count_d;

  // ---- Pixel clock divider ------------------------------------------------

  assign pixel_en = (div_q == DIV_LAST);

  always_comb begin
    div_d = pixel_en ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

  // ---- Scan position -------------------------------------------------------
  // The vertical counter steps only on the pixel that ends a line, so its
  // wrap marks the last pixel of the frame.

  scan_counter #(.TOTAL(H_TOT)) u_hcount (
    .clk   (Clk),
    .clr_n (Reset_n),
    .en    (pixel_en),
    .count (hc),
    .wrap  (h_wrap)
  );

  scan_counter #(.TOTAL(V_TOT)) u_vcount (
    .clk   (Clk),
    .clr_n (Reset_n),
    .en    (h_wrap),
    .count (vc),
    .wrap  (v_wrap)
  );

  assign DrawX = hc;
  assign DrawY = vc;

  // ---- Position decode -----------------------------------------------------

  assign hs_raw = in_window(hc, HS_FIRST_C, HS_LAST_C);
  assign vs_raw = in_window(vc, VS_FIRST_C, VS_LAST_C);
  assign vis    = (hc < H_VIS_C) && (vc < V_VIS_C);

  assign pix_rgb = '{r: Red, g: Green, b: Blue};

  // ---- Output stage --------------------------------------------------------
  // Sync, blank and colour are all captured on the same pixel strobe so the
  // DAC sees a consistent pixel. The colour is forced to black in blanking.
  // The frame tick follows the frame wrap by one clock and lasts one clock.

  always_comb begin
    hs_n_d        = hs_n_q;
    vs_n_d        = vs_n_q;
    blank_n_d     = blank_n_q;
    rgb_d         = rgb_q;
    frame_count_d = frame_count_q;
    frame_start_d = v_wrap;
    if (pixel_en) begin
      hs_n_d    = ~hs_raw;
      vs_n_d    = ~vs_raw;
      blank_n_d = vis;
      rgb_d     = vis ? pix_rgb : '0;
    end
    if (v_wrap) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hs_n_q        <= 1'b1;
      vs_n_q        <= 1'b1;
      blank_n_q     <= 1'b0;
      rgb_q         <= '0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      hs_n_q        <= hs_n_d;
      vs_n_q        <= vs_n_d;
      blank_n_q     <= blank_n_d;
      rgb_q         <= rgb_d;
      frame_start_q <= frame_start_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign VGA_HS      = hs_n_q;
  assign VGA_VS      = vs_n_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_R       = rgb_q.r;
  assign VGA_G       = rgb_q.g;
  assign VGA_B       = rgb_q.b;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_scan_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_scan_generator
//
// Bench for vga_scan_generator using a shrunken raster so whole frames, and
// the 8-bit frame counter wrap, fit in a short run. Expected behaviour is
// derived from the number of clocks since reset release: pixel index,
// beam position, frame number and the sync/blank windows all follow from
// plain arithmetic on that count.
// ---------------------------------------------------------------------------
module tb_vga_scan_generator;

  localparam int CD  = 2;
  localparam int HV  = 11;
  localparam int HFP = 1;
  localparam int HSY = 2;
  localparam int HBP = 1;
  localparam int VV  = 6;
  localparam int VFP = 1;
  localparam int VSY = 2;
  localparam int VBP = 0;
  localparam int HT  = HV + HFP + HSY + HBP;
  localparam int VT  = VV + VFP + VSY + VBP;
  localparam int FRAME_PX  = HT * VT;
  localparam int FRAME_CLK = FRAME_PX * CD;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       pixel_en;
  logic [9:0] DrawX, DrawY;
  logic [7:0] Red = 8'h00, Green = 8'h00, Blue = 8'h00;
  logic       VGA_HS, VGA_VS, VGA_BLANK_N;
  logic [7:0] VGA_R, VGA_G, VGA_B;
  logic       frame_start;
  logic [7:0] frame_count;

  int testsRun  = 0;
  int failCount = 0;

  longint      tCnt;
  int          colorMode = 0;
  logic [23:0] pendingColor = 24'h0;
  logic [23:0] lastColor    = 24'h0;

  typedef struct packed {
    int          x;
    int          y;
    int          fc;
    logic        pe;
    logic        hsN;
    logic        vsN;
    logic        blankN;
    logic        fs;
    logic [23:0] rgb;
  } exp_t;

  vga_scan_generator #(
    .CLK_DIV(CD), .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
    .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .pixel_en(pixel_en),
    .DrawX(DrawX), .DrawY(DrawY),
    .Red(Red), .Green(Green), .Blue(Blue),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .frame_start(frame_start), .frame_count(frame_count)
  );

  always #5 Clk = ~Clk;

  // Clock edges seen since the last reset release.
  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) tCnt <= 0;
    else          tCnt <= tCnt + 1;
  end

  function automatic logic hsOn(int x);
    return (x >= HV + HFP) && (x <= HV + HFP + HSY - 1);
  endfunction

  function automatic logic vsOn(int y);
    return (y >= VV + VFP) && (y <= VV + VFP + VSY - 1);
  endfunction

  // Expected DUT state after t clock edges; prevColor is the colour that was
  // presented for the pixel before the current one.
  function automatic exp_t model(longint t, logic [23:0] prevColor);
    exp_t   e;
    longint p;
    longint q;
    int     qx;
    int     qy;
    p   = t / CD;
    e.x = int'(p % HT);
    e.y = int'((p / HT) % VT);
    e.pe = ((t % CD) == CD - 1);
    e.fc = int'((p / FRAME_PX) % 256);
    e.fs = ((t % CD) == 0) && (p > 0) && ((p % FRAME_PX) == 0);
    if (p == 0) begin
      e.hsN = 1'b1; e.vsN = 1'b1; e.blankN = 1'b0; e.rgb = 24'h0;
    end else begin
      q  = p - 1;
      qx = int'(q % HT);
      qy = int'((q / HT) % VT);
      e.hsN    = !hsOn(qx);
      e.vsN    = !vsOn(qy);
      e.blankN = (qx < HV) && (qy < VV);
      e.rgb    = e.blankN ? prevColor : 24'h0;
    end
    return e;
  endfunction

  // Move to the next falling clock edge and act as the colour mapper.
  task automatic advance();
    logic [23:0] c;
    @(negedge Clk);
    if ((tCnt % CD) == 0 && tCnt > 0) lastColor = pendingColor;
    case (colorMode)
      1:       c = (DrawX == 10'd10 && DrawY == 10'd5) ? 24'hFF5500 : 24'h000000;
      2:       c = (DrawX == 10'(HV)) ? 24'hFF0000 : 24'h000000;
      default: c = 24'($urandom);
    endcase
    if ((tCnt % CD) == CD - 1) pendingColor = c;
    {Red, Green, Blue} = c;
  endtask

  // Advance until a pixel strobe at the requested position (bounded).
  task automatic syncTo(input int x, input int y, input bit anyY, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME_CLK + 4; i++) begin
      advance();
      if (pixel_en === 1'b1 && DrawX == 10'(x) && (anyY || DrawY == 10'(y))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1 Reset_n = 1'b0;
    repeat (3) advance();
    testsRun++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0) begin
      failCount++;
      $display("[TB] FAIL reset_coords: got (%0d,%0d) expected (0,0)", DrawX, DrawY);
    end
    testsRun++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_N} !== 3'b110) begin
      failCount++;
      $display("[TB] FAIL reset_sync: got HS/VS/BLANK_N=%b expected 110", {VGA_HS, VGA_VS, VGA_BLANK_N});
    end
    testsRun++;
    if ({VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      failCount++;
      $display("[TB] FAIL reset_rgb: got %h expected 000000", {VGA_R, VGA_G, VGA_B});
    end
    testsRun++;
    if (frame_start !== 1'b0 || frame_count !== 8'd0 || pixel_en !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL reset_frame: got fs=%b fc=%0d pe=%b expected 0 0 0", frame_start, frame_count, pixel_en);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_pixel_en();
    for (int i = 1; i <= 8; i++) begin
      advance();
      testsRun++;
      if (pixel_en !== ((i % 2) == 1) || DrawX !== 10'(i / 2)) begin
        failCount++;
        $display("[TB] FAIL pixel_en_cycle%0d: got pe=%b x=%0d expected pe=%0d x=%0d", i, pixel_en, DrawX, (i % 2), i / 2);
      end
    end
  endtask

  task automatic test_frame_tick();
    int     events = 0;
    longint lastT  = 0;
    for (int i = 0; i < 4 * FRAME_CLK && events < 3; i++) begin
      advance();
      if (frame_start === 1'b1) begin
        events++;
        testsRun++;
        if (tCnt != longint'(events) * FRAME_CLK || (events > 1 && tCnt - lastT != FRAME_CLK)) begin
          failCount++;
          $display("[TB] FAIL frame_tick_time%0d: got t=%0d expected t=%0d", events, tCnt, events * FRAME_CLK);
        end
        testsRun++;
        if (frame_count !== 8'(events)) begin
          failCount++;
          $display("[TB] FAIL frame_tick_count%0d: got %0d expected %0d", events, frame_count, events);
        end
        lastT = tCnt;
        advance();
        testsRun++;
        if (frame_start !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL frame_tick_width%0d: got fs=%b one clock later expected 0", events, frame_start);
        end
      end
    end
    testsRun++;
    if (events != 3) begin
      failCount++;
      $display("[TB] FAIL frame_tick_seen: got %0d pulses expected 3", events);
    end
  endtask

  task automatic test_hsync();
    bit ok;
    int lowCount = 0, firstLow = -1, lastLow = -1, unstable = 0, prevX;
    logic hsA;
    syncTo(0, 0, 1'b1, ok);
    for (int i = 0; i < HT && ok; i++) begin
      prevX = int'(DrawX);
      advance();
      hsA = VGA_HS;
      advance();
      if (hsA !== VGA_HS) unstable++;
      if (VGA_HS === 1'b0) begin
        lowCount++;
        if (firstLow < 0) firstLow = prevX;
        lastLow = prevX;
      end
    end
    testsRun++;
    if (!ok || lowCount != HSY || firstLow != HV + HFP || lastLow != HV + HFP + HSY - 1) begin
      failCount++;
      $display("[TB] FAIL hsync_window: got low=%0d first=%0d last=%0d expected %0d %0d %0d",
               lowCount, firstLow, lastLow, HSY, HV + HFP, HV + HFP + HSY - 1);
    end
    testsRun++;
    if (unstable != 0) begin
      failCount++;
      $display("[TB] FAIL hsync_stable: got %0d mid-pixel changes expected 0", unstable);
    end
  endtask

  task automatic test_vsync_blank();
    bit ok;
    int blankHigh = 0, vsLow = 0, firstY = -1, lastY = -1, prevY;
    syncTo(0, 0, 1'b0, ok);
    for (int i = 0; i < FRAME_PX && ok; i++) begin
      prevY = int'(DrawY);
      repeat (CD) advance();
      if (VGA_BLANK_N === 1'b1) blankHigh++;
      if (VGA_VS === 1'b0) begin
        vsLow++;
        if (firstY < 0) firstY = prevY;
        lastY = prevY;
      end
    end
    testsRun++;
    if (!ok || vsLow != VSY * HT || firstY != VV + VFP || lastY != VV + VFP + VSY - 1) begin
      failCount++;
      $display("[TB] FAIL vsync_window: got low=%0d first=%0d last=%0d expected %0d %0d %0d",
               vsLow, firstY, lastY, VSY * HT, VV + VFP, VV + VFP + VSY - 1);
    end
    testsRun++;
    if (blankHigh != HV * VV) begin
      failCount++;
      $display("[TB] FAIL blank_count: got %0d expected %0d", blankHigh, HV * VV);
    end
  endtask

  task automatic test_color_path();
    bit ok;
    int errs = 0, hits = 0, prevX, prevY, edgeSeen = 0;
    logic [23:0] want;
    colorMode = 1;
    syncTo(0, 0, 1'b0, ok);
    for (int i = 0; i < FRAME_PX && ok; i++) begin
      prevX = int'(DrawX);
      prevY = int'(DrawY);
      repeat (CD) advance();
      want = (prevX == 10 && prevY == 5) ? 24'hFF5500 : 24'h000000;
      if ({VGA_R, VGA_G, VGA_B} !== want) errs++;
      if (VGA_R === 8'hFF) hits++;
    end
    testsRun++;
    if (!ok || errs != 0 || hits != 1) begin
      failCount++;
      $display("[TB] FAIL color_single_pixel: got errs=%0d hits=%0d expected 0 1", errs, hits);
    end
    colorMode = 2;
    syncTo(0, 1, 1'b0, ok);
    for (int i = 0; i < HT && ok; i++) begin
      prevX = int'(DrawX);
      repeat (CD) advance();
      if (prevX == HV) begin
        edgeSeen++;
        testsRun++;
        if (VGA_R !== 8'h00 || VGA_BLANK_N !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL color_blanked: got R=%h BLANK_N=%b expected 00 0", VGA_R, VGA_BLANK_N);
        end
      end
    end
    testsRun++;
    if (edgeSeen != 1) begin
      failCount++;
      $display("[TB] FAIL color_blanked_seen: got %0d expected 1", edgeSeen);
    end
    colorMode = 0;
  endtask

  task automatic test_random_scan(input int nClk);
    exp_t e;
    for (int i = 0; i < nClk; i++) begin
      advance();
      e = model(tCnt, lastColor);
      testsRun++;
      if (DrawX !== 10'(e.x) || DrawY !== 10'(e.y) || pixel_en !== e.pe) begin
        failCount++;
        $display("[TB] FAIL scan_pos t=%0d: got (%0d,%0d) pe=%b expected (%0d,%0d) pe=%b",
                 tCnt, DrawX, DrawY, pixel_en, e.x, e.y, e.pe);
      end
      testsRun++;
      if ({VGA_HS, VGA_VS, VGA_BLANK_N} !== {e.hsN, e.vsN, e.blankN}) begin
        failCount++;
        $display("[TB] FAIL scan_sync t=%0d: got HS/VS/BLANK_N=%b expected %b",
                 tCnt, {VGA_HS, VGA_VS, VGA_BLANK_N}, {e.hsN, e.vsN, e.blankN});
      end
      testsRun++;
      if ({VGA_R, VGA_G, VGA_B} !== e.rgb) begin
        failCount++;
        $display("[TB] FAIL scan_rgb t=%0d: got %h expected %h", tCnt, {VGA_R, VGA_G, VGA_B}, e.rgb);
      end
      testsRun++;
      if (frame_start !== e.fs || frame_count !== 8'(e.fc)) begin
        failCount++;
        $display("[TB] FAIL scan_frame t=%0d: got fs=%b fc=%0d expected fs=%b fc=%0d",
                 tCnt, frame_start, frame_count, e.fs, e.fc);
      end
    end
  endtask

  task automatic test_midframe_reset();
    bit ok;
    syncTo(5, 4, 1'b0, ok);
    #2;
    testsRun++;
    if (!ok || VGA_BLANK_N !== 1'b1 || frame_count === 8'd0) begin
      failCount++;
      $display("[TB] FAIL midreset_pre: got ok=%0d BLANK_N=%b fc=%0d expected 1 1 nonzero", ok, VGA_BLANK_N, frame_count);
    end
    Reset_n = 1'b0;
    #1;
    testsRun++;
    if (DrawX !== 10'd0 || DrawY !== 10'd0 || pixel_en !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL midreset_pos: got (%0d,%0d) pe=%b expected (0,0) 0", DrawX, DrawY, pixel_en);
    end
    testsRun++;
    if ({VGA_HS, VGA_VS, VGA_BLANK_N} !== 3'b110 || {VGA_R, VGA_G, VGA_B} !== 24'h0) begin
      failCount++;
      $display("[TB] FAIL midreset_out: got sync=%b rgb=%h expected 110 000000",
               {VGA_HS, VGA_VS, VGA_BLANK_N}, {VGA_R, VGA_G, VGA_B});
    end
    testsRun++;
    if (frame_start !== 1'b0 || frame_count !== 8'd0) begin
      failCount++;
      $display("[TB] FAIL midreset_frame: got fs=%b fc=%0d expected 0 0", frame_start, frame_count);
    end
    advance();
    Reset_n = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      advance();
      testsRun++;
      if (DrawX !== 10'(i / 2) || DrawY !== 10'd0 || pixel_en !== ((i % 2) == 1) || frame_count !== 8'd0) begin
        failCount++;
        $display("[TB] FAIL midreset_restart%0d: got (%0d,%0d) pe=%b fc=%0d expected (%0d,0) pe=%0d fc=0",
                 i, DrawX, DrawY, pixel_en, frame_count, i / 2, i % 2);
      end
    end
  endtask

  task automatic test_frame_wrap();
    int     badEvents = 0;
    bit     wrapped   = 1'b0;
    longint wrapT     = 0;
    longint fcExp;
    for (int i = 0; i < 257 * FRAME_CLK && !wrapped; i++) begin
      advance();
      if (frame_start === 1'b1) begin
        fcExp = (tCnt / FRAME_CLK) % 256;
        if ((tCnt % FRAME_CLK) != 0 || frame_count !== 8'(fcExp)) badEvents++;
        if (frame_count === 8'd0) begin
          wrapped = 1'b1;
          wrapT   = tCnt;
        end
        advance();
        if (frame_start !== 1'b0) badEvents++;
      end
    end
    testsRun++;
    if (badEvents != 0) begin
      failCount++;
      $display("[TB] FAIL wrap_sequence: got %0d bad frame ticks expected 0", badEvents);
    end
    testsRun++;
    if (!wrapped || wrapT != 256 * longint'(FRAME_CLK)) begin
      failCount++;
      $display("[TB] FAIL wrap_to_zero: got seen=%0d t=%0d expected seen=1 t=%0d", wrapped, wrapT, 256 * FRAME_CLK);
    end
  endtask

  initial begin
    test_reset();
    test_pixel_en();
    test_frame_tick();
    test_hsync();
    test_vsync_blank();
    test_color_path();
    test_random_scan(600);
    test_midframe_reset();
    test_random_scan(300);
    test_frame_wrap();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
